pll_lock_ctrl: RTL and testbench

PLL reset and lock supervisor for the ECP5 clock generators. Runs on the free-running board oscillator (the PLL's input clock), drives the PLL `RST` pin, synchronises and qualifies the raw PLL `LOCK` output, and issues the system reset. It retries a PLL that fails to lock, reports permanent failure, and counts lock-loss events.

---
 rtl/pll_lock_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pll_lock_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_ctrl.sv
// PLL reset and lock supervisor.
// Runs on the free-running oscillator. It pulses the PLL reset, then waits for a
// synchronised lock that stays high long enough before releasing the system reset.
// A PLL that fails to lock in time is retried, and the block gives up after
// MAX_RETRIES attempts (0 = retry forever). Lock losses seen while running are
// counted in a saturating counter.
module pll_lock_ctrl #(
    parameter int PLL_RST_LEN   = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       clear_count,
    output logic       pll_rst,
    output logic       rst_sys_n,
    output logic       ready,
    output logic       fail,
    output logic [7:0] loss_count
);

    localparam int RST_W = (PLL_RST_LEN   > 1) ? $clog2(PLL_RST_LEN)   : 1;
    localparam int TMR_W = (LOCK_TIMEOUT  > 1) ? $clog2(LOCK_TIMEOUT)  : 1;
    localparam int STB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int RTY_W = (MAX_RETRIES   > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [RST_W-1:0] RST_LAST = RST_W'(PLL_RST_LEN - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_t;

    state_t state, next_state;

    logic             lock_m;
    logic             lock_s;
    logic [RST_W-1:0] rst_cnt;
    logic [TMR_W-1:0] timer;
    logic [STB_W-1:0] stb_cnt;
    logic [RTY_W-1:0] retry_cnt;
    logic [RTY_W-1:0] retry_next;

    logic timeout;
    logic stable_done;
    logic retry_exhausted;

    logic pll_rst_d;
    logic rst_sys_n_d;
    logic ready_d;
    logic fail_d;

    // The lock timer expiring in either waiting state ends the current attempt.
    assign timeout         = ((state == WAIT_LOCK) || (state == STABLE)) && (timer == TMR_LAST);
    assign stable_done     = (state == STABLE) && lock_s && (stb_cnt == STB_LAST);
    assign retry_next      = retry_cnt + RTY_W'(1);
    assign retry_exhausted = (MAX_RETRIES != 0) && (retry_next == RTY_MAX);

    // Two-flop synchroniser for the asynchronous PLL lock output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= pll_locked;
            lock_s <= lock_m;
        end
    end

    // State register; outputs are registered from the next-state decode so they
    // change on the same edge as the state and cannot glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RESET_PLL;
            pll_rst   <= 1'b1;
            rst_sys_n <= 1'b0;
            ready     <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state     <= next_state;
            pll_rst   <= pll_rst_d;
            rst_sys_n <= rst_sys_n_d;
            ready     <= ready_d;
            fail      <= fail_d;
        end
    end

    // Next-state logic; a stable completion beats a timeout on the same edge.
    always_comb begin
        next_state = state;
        case (state)
            RESET_PLL: begin
                if (rst_cnt == RST_LAST) next_state = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (timeout)     next_state = retry_exhausted ? FAIL : RESET_PLL;
                else if (lock_s) next_state = STABLE;
            end
            STABLE: begin
                if (stable_done)  next_state = RUN;
                else if (timeout) next_state = retry_exhausted ? FAIL : RESET_PLL;
                else if (!lock_s) next_state = WAIT_LOCK;
            end
            RUN: begin
                if (!lock_s) next_state = RESET_PLL;
            end
            FAIL: begin
                next_state = FAIL;
            end
            default: next_state = RESET_PLL;
        endcase
    end

    // Output decode of the state being entered.
    always_comb begin
        pll_rst_d   = (next_state == RESET_PLL);
        rst_sys_n_d = (next_state == RUN);
        ready_d     = (next_state == RUN);
        fail_d      = (next_state == FAIL);
    end

    // Reset-length, lock-timeout, stable and retry counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_cnt   <= '0;
            timer     <= '0;
            stb_cnt   <= '0;
            retry_cnt <= '0;
        end else begin
            // Counts edges spent in RESET_PLL; zero whenever the state is left.
            if ((state == RESET_PLL) && (next_state == RESET_PLL)) rst_cnt <= rst_cnt + RST_W'(1);
            else                                                   rst_cnt <= '0;

            // The timer spans the whole attempt, so a flap back to WAIT_LOCK keeps it running.
            if (state == RESET_PLL)                               timer <= '0;
            else if ((state == WAIT_LOCK) || (state == STABLE))   timer <= timer + TMR_W'(1);

            if ((state == STABLE) && (next_state == STABLE)) stb_cnt <= stb_cnt + STB_W'(1);
            else                                             stb_cnt <= '0;

            if ((next_state == RUN) && (state != RUN)) retry_cnt <= '0;
            else if (timeout && !stable_done)          retry_cnt <= retry_next;
        end
    end

    // Saturating lock-loss counter; a clear overrides a simultaneous loss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loss_count <= 8'd0;
        end else if (clear_count) begin
            loss_count <= 8'd0;
        end else if ((state == RUN) && !lock_s && (loss_count != 8'd255)) begin
            loss_count <= loss_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl with small timing parameters.
// Instance a retries forever; instance b gives up after three attempts.
module tb_pll_lock_ctrl;

    logic       clk = 1'b0;
    logic       rst_n_a, pll_locked_a, clear_a;
    logic       pll_rst_a, rst_sys_n_a, ready_a, fail_a;
    logic [7:0] loss_a;
    logic       rst_n_b, pll_locked_b, clear_b;
    logic       pll_rst_b, rst_sys_n_b, ready_b, fail_b;
    logic [7:0] loss_b;

    int checks;
    int errors;

    always #5 clk = ~clk;

    pll_lock_ctrl #(
        .PLL_RST_LEN(4), .LOCK_TIMEOUT(64), .STABLE_CYCLES(8), .MAX_RETRIES(0)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n_a), .pll_locked(pll_locked_a), .clear_count(clear_a),
        .pll_rst(pll_rst_a), .rst_sys_n(rst_sys_n_a), .ready(ready_a), .fail(fail_a),
        .loss_count(loss_a)
    );

    pll_lock_ctrl #(
        .PLL_RST_LEN(4), .LOCK_TIMEOUT(64), .STABLE_CYCLES(8), .MAX_RETRIES(3)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n_b), .pll_locked(pll_locked_b), .clear_count(clear_b),
        .pll_rst(pll_rst_b), .rst_sys_n(rst_sys_n_b), .ready(ready_b), .fail(fail_b),
        .loss_count(loss_b)
    );

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for instance a to reach RUN.
    task automatic wait_ready_a(input string tag);
        int n;
        n = 0;
        while (!ready_a && n < 200) begin
            tick(1);
            n++;
        end
        check(tag, ready_a, 1);
    endtask

    initial begin
        int pulses, high, fail_edge;
        logic prev, rdy_seen, flap_run;

        checks = 0; errors = 0;
        rst_n_a = 1'b0; pll_locked_a = 1'b0; clear_a = 1'b0;
        rst_n_b = 1'b0; pll_locked_b = 1'b0; clear_b = 1'b0;
        tick(3);

        // Reset values
        check("rst_pll_rst", pll_rst_a, 1);
        check("rst_rst_sys_n", rst_sys_n_a, 0);
        check("rst_ready", ready_a, 0);
        check("rst_fail", fail_a, 0);
        check("rst_loss", loss_a, 0);
        check("rst_fail_b", fail_b, 0);

        // Normal lock: release is edge 0, pll_locked rises after edge 20
        rst_n_a = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            tick(1);
            check("rst_pulse_len", pll_rst_a, (e < 4) ? 1 : 0);
        end
        tick(16);
        pll_locked_a = 1'b1;
        tick(10);
        check("lock_ready_early", ready_a, 0);
        tick(1);
        check("lock_ready_e31", ready_a, 1);
        check("lock_rst_sys_n_e31", rst_sys_n_a, 1);
        check("lock_pll_rst_low", pll_rst_a, 0);
        check("lock_loss_zero", loss_a, 0);

        // Lock loss in RUN: drop after edge 40, restore after edge 60
        tick(9);
        pll_locked_a = 1'b0;
        tick(2);
        check("loss_ready_e42", ready_a, 1);
        tick(1);
        check("loss_rst_sys_n_e43", rst_sys_n_a, 0);
        check("loss_ready_e43", ready_a, 0);
        check("loss_pll_rst_e43", pll_rst_a, 1);
        check("loss_count_1", loss_a, 1);
        tick(3);
        check("loss_pulse_e46", pll_rst_a, 1);
        tick(1);
        check("loss_pulse_end_e47", pll_rst_a, 0);
        tick(13);
        pll_locked_a = 1'b1;
        tick(10);
        check("relock_ready_e70", ready_a, 0);
        tick(1);
        check("relock_ready_e71", ready_a, 1);

        // Asynchronous reset from RUN clears everything including loss_count
        #3;
        rst_n_a = 1'b0;
        pll_locked_a = 1'b0;
        #1;
        check("arst_run_pll_rst", pll_rst_a, 1);
        check("arst_run_ready", ready_a, 0);
        check("arst_run_rst_sys_n", rst_sys_n_a, 0);
        check("arst_run_loss", loss_a, 0);

        // Flapping lock: high after 20, low after 25, high for good after 26
        tick(2);
        rst_n_a = 1'b1;
        tick(20);
        pll_locked_a = 1'b1;
        tick(5);
        pll_locked_a = 1'b0;
        tick(1);
        pll_locked_a = 1'b1;
        flap_run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (ready_a) flap_run = 1'b1;
        end
        check("flap_no_early_run", flap_run, 0);
        tick(1);
        check("flap_ready_e37", ready_a, 1);

        // Reset pulsed mid-STABLE with the lock held high throughout
        #3;
        rst_n_a = 1'b0;
        #1;
        tick(1);
        rst_n_a = 1'b1;
        tick(8);
        check("stable_ready_e8", ready_a, 0);
        check("stable_pll_rst_e8", pll_rst_a, 0);
        #2;
        rst_n_a = 1'b0;
        #1;
        check("arst_stable_pll_rst", pll_rst_a, 1);
        check("arst_stable_rst_sys_n", rst_sys_n_a, 0);
        tick(1);
        rst_n_a = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            tick(1);
            check("restart_pulse_len", pll_rst_a, (e < 4) ? 1 : 0);
        end
        tick(8);
        check("restart_ready_e12", ready_a, 0);
        tick(1);
        check("restart_ready_e13", ready_a, 1);

        // 260 lock losses: counter saturates at 255
        for (int i = 1; i <= 260; i++) begin
            pll_locked_a = 1'b0;
            tick(3);
            pll_locked_a = 1'b1;
            wait_ready_a("sat_relock");
            if (i == 1)   check("sat_count_1", loss_a, 1);
            if (i == 255) check("sat_count_255", loss_a, 255);
        end
        check("sat_count_260", loss_a, 255);

        // Clear on the same edge as a loss: clear wins
        pll_locked_a = 1'b0;
        tick(2);
        clear_a = 1'b1;
        tick(1);
        check("clear_vs_loss", loss_a, 0);
        check("clear_pll_rst", pll_rst_a, 1);
        clear_a = 1'b0;

        // Never lock: a retries forever, b fails after 3 attempts at edge 204
        rst_n_a = 1'b0;
        pll_locked_a = 1'b0;
        tick(1);
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        pulses = 0; high = 0; fail_edge = -1;
        prev = 1'b0; rdy_seen = 1'b0;
        for (int e = 0; e <= 280; e++) begin
            if (e > 0) tick(1);
            if (pll_rst_b) begin
                high++;
                if (!prev) pulses++;
            end
            prev = pll_rst_b;
            if (fail_b && fail_edge < 0) fail_edge = e;
            if (ready_b) rdy_seen = 1'b1;
            if (e == 204 || e == 272) check("forever_pulse", pll_rst_a, 1);
        end
        check("forever_no_fail", fail_a, 0);
        check("nolock_pulses", pulses, 3);
        check("nolock_pulse_cycles", high, 12);
        check("nolock_fail_edge", fail_edge, 204);
        check("nolock_never_ready", rdy_seen, 0);
        check("fail_pll_rst", pll_rst_b, 0);
        check("fail_rst_sys_n", rst_sys_n_b, 0);

        // Reset from FAIL
        #3;
        rst_n_b = 1'b0;
        #1;
        check("arst_fail_fail", fail_b, 0);
        check("arst_fail_pll_rst", pll_rst_b, 1);
        check("arst_fail_rst_sys_n", rst_sys_n_b, 0);
        tick(1);
        rst_n_b = 1'b1;
        tick(3);
        check("fail_restart_e3", pll_rst_b, 1);
        tick(1);
        check("fail_restart_e4", pll_rst_b, 0);
        check("fail_restart_no_fail", fail_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
